exec_alu: RTL and testbench
===========================

# exec_alu

Registered execute-stage ALU for the RISC-V core. It sits directly downstream of the ALU control decoder and consumes its 4-bit `ALUCtrl` code together with the two operands from the ID/EX path. It returns a registered result plus zero and branch-taken flags to the EX/MEM side over a valid/ready handshake. Logic ops, add and sub finish in one cycle; SLL and SRL use an iterative 1-bit-per-cycle shifter, so the unit stalls upstream while a shift is in progress.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default 5: shift-amount width, equal to log2(`DATA_WIDTH`).

Ports:
- `clk_i`  in  1  clock. Single clock domain; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `valid_i`  in  1  upstream operation valid.
- `ready_o`  out  1  unit can accept an operation this cycle (combinational).
- `ALUCtrl_i`  in  4  operation code from ALU control.
- `src1_i`  in  DATA_WIDTH  operand A (rs1).
- `src2_i`  in  DATA_WIDTH  operand B (rs2 or immediate); bits [SHAMT_WIDTH-1:0] give the shift amount.
- `valid_o`  out  1  result registers hold an unconsumed result.
- `ready_i`  in  1  downstream consumes the result this cycle.
- `result_o`  out  DATA_WIDTH  registered result.
- `zero_o`  out  1  registered, result_o == 0.
- `branch_o`  out  1  registered branch-taken flag.

## Operation
Op codes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 SUB
- 0100 SLL
- 0101 SRL (logical, zero fill)
- 0110 BEQ: result = A−B; branch_o = (A==B)
- 0111 XOR
- 1001 BNE: result = A−B; branch_o = (A!=B)
- All other codes: result 0, zero_o 1, branch_o 0, single-cycle.

Arithmetic and flags:
- Add and sub wrap modulo 2^DATA_WIDTH; no overflow or carry outputs.
- branch_o is 0 for every op other than BEQ and BNE.

FSM states:
- IDLE: accepts work; ready_o = (!valid_o || ready_i).
- SHIFT: ready_o = 0. Holds a working register and a down-counter `cnt`.

Transitions:
- IDLE, accept (valid_i && ready_o), non-shift op: result registers load, valid_o←1, stay IDLE.
- IDLE, accept, shift with shamt==0: result←A, valid_o←1, stay IDLE.
- IDLE, accept, shift with shamt≥1: work←A shifted by 1, cnt←shamt−1.
  - If cnt==0, result←work, valid_o←1, stay IDLE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle work shifts by 1 and cnt decrements. At the cycle where cnt==1, the final shifted value is written to result_o, valid_o←1, and the FSM returns to IDLE. The last shift of a multi-cycle shift therefore writes the results directly to the output registers.
- A shift does not enter its final result-load cycle while valid_o is high and ready_i is low; it waits in SHIFT with cnt==1 until the output slot is free.

Output handshake:
- valid_o clears on a cycle with ready_i && valid_o unless a new result loads on the same edge.
- While valid_o && !ready_i, result_o, zero_o and branch_o are held stable.

## Timing
- Reset (synchronous, rst_i high at an edge):
  - state IDLE, cnt 0, work 0.
  - valid_o 0, result_o 0, zero_o 0, branch_o 0.
  - ready_o 1 in the cycle after reset deasserts.
- Reset during SHIFT aborts the operation. No result is produced.
- Latency from the accept edge to valid_o high:
  - 1 cycle for non-shift ops and for shamt 0 or 1.
  - shamt cycles for shamt ≥ 2, with no backpressure.
- Throughput: one non-shift op per cycle, including same-cycle consume and accept (valid_o && ready_i && valid_i).
- ready_o is 0 throughout SHIFT, and 0 in IDLE when valid_o && !ready_i.
- Inputs are sampled only on the accept edge; changes to ALUCtrl_i, src1_i or src2_i during SHIFT have no effect.

## Test plan
- Reset:
  - Hold rst_i for 2 cycles with valid_i=1 → valid_o=0, result_o=0, zero_o=0, branch_o=0.
  - First accept occurs the cycle after release.
- Back-to-back single-cycle ops, ready_i=1, valid_i=1 every cycle → results appear on consecutive cycles:
  - ADD 0xFFFFFFFF+1 → 0, zero_o=1.
  - SUB 5−7 → 0xFFFFFFFE.
  - XOR 0xF0F0F0F0^0xFF00FF00 → 0x0FF00FF0.
  - OR 1|2 → 3.
  - AND 6&3 → 2.
- Branches:
  - BEQ A=B=0x1234 → branch_o=1, zero_o=1.
  - BNE A=0x1234, B=0x1235 → branch_o=1, result 0xFFFFFFFF.
  - BNE A=B → branch_o=0.
- Shifts:
  - SLL 0x00000001 by 31 → 0x80000000, with valid_o exactly 31 cycles after accept and ready_o low for 30 cycles.
  - SRL 0x80000000 by 4 → 0x08000000.
  - SLL by 0 → 1-cycle latency, result = A.
- Backpressure:
  - Hold ready_i=0 with a result pending → result_o stable, ready_o=0.
  - Launch SRL by 3 while the output is blocked, then raise ready_i → first result consumed, then the shift result is delivered; no result lost or duplicated.
- Reset mid-shift and undefined code:
  - Assert rst_i at cycle 5 of an SLL by 20 → no valid_o afterwards and the FSM is back in IDLE.
  - ALUCtrl 1111 → result 0, zero_o 1, branch_o 0, 1-cycle latency.

Source files
------------

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - registered execute-stage ALU with iterative 1-bit-per-cycle shifter
module exec_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            ALUCtrl_i,
  input  logic [DATA_WIDTH-1:0] src1_i,
  input  logic [DATA_WIDTH-1:0] src2_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  branch_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_BNE = 4'b1001;

  logic [0:0]             state;
  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   shift_right;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   is_srl;
  logic                   accept;
  logic                   out_free;
  logic [DATA_WIDTH-1:0]  first_shift;
  logic [DATA_WIDTH-1:0]  next_work;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_br;

  assign shamt       = src2_i[SHAMT_WIDTH-1:0];
  assign is_srl      = (ALUCtrl_i == OP_SRL);
  assign is_shift    = (ALUCtrl_i == OP_SLL) || is_srl;
  assign out_free    = !valid_o || ready_i;
  assign ready_o     = (state == ST_IDLE) && out_free;
  assign accept      = valid_i && ready_o;
  assign first_shift = is_srl ? (src1_i >> 1) : (src1_i << 1);
  assign next_work   = shift_right ? (work >> 1) : (work << 1);

  // Single-cycle result; shifts only land here for shamt 0 or 1
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (ALUCtrl_i)
      OP_AND: alu_res = src1_i & src2_i;
      OP_OR:  alu_res = src1_i | src2_i;
      OP_ADD: alu_res = src1_i + src2_i;
      OP_SUB: alu_res = src1_i - src2_i;
      OP_XOR: alu_res = src1_i ^ src2_i;
      OP_SLL, OP_SRL: alu_res = (shamt == '0) ? src1_i : first_shift;
      OP_BEQ: begin
        alu_res = src1_i - src2_i;
        alu_br  = (src1_i == src2_i);
      end
      OP_BNE: begin
        alu_res = src1_i - src2_i;
        alu_br  = (src1_i != src2_i);
      end
      default: begin
        alu_res = '0;
        alu_br  = 1'b0;
      end
    endcase
  end

  // Control FSM, shifter datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      work        <= '0;
      cnt         <= '0;
      shift_right <= 1'b0;
      valid_o     <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      branch_o    <= 1'b0;
    end else begin
      // A consumed result drops unless a new one overwrites it below
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt > SHAMT_WIDTH'(1))) begin
              work        <= first_shift;
              cnt         <= shamt - 1'b1;
              shift_right <= is_srl;
              state       <= ST_SHIFT;
            end else begin
              result_o <= alu_res;
              zero_o   <= (alu_res == '0);
              branch_o <= alu_br;
              valid_o  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt == SHAMT_WIDTH'(1)) begin
            // Final shift writes straight into the output slot once it is free
            if (out_free) begin
              work     <= next_work;
              cnt      <= '0;
              result_o <= next_work;
              zero_o   <= (next_work == '0);
              branch_o <= 1'b0;
              valid_o  <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            work <= next_work;
            cnt  <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_alu.sv
// tb/tb_exec_alu.sv - self-checking bench for exec_alu against a behavioural model
module tb_exec_alu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        branch_o;

  int n_asserts = 0;
  int n_fail    = 0;

  exec_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ALUCtrl_i(ALUCtrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .branch_o (branch_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: {branch, zero, result} straight from the op table
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        br;
    r  = 32'd0;
    br = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a - b;
      4'd4: r = a << b[4:0];
      4'd5: r = a >> b[4:0];
      4'd6: begin r = a - b; br = (a == b); end
      4'd7: r = a ^ b;
      4'd9: begin r = a - b; br = (a != b); end
      default: r = 32'd0;
    endcase
    return {br, (r == 32'd0), r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op: accepted on the next edge, result visible right after it
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] m;
    m         = model(op, a, b);
    valid_i   = 1'b1;
    ready_i   = 1'b1;
    ALUCtrl_i = op;
    src1_i    = a;
    src2_i    = b;
    #1;
    check("ready_before_accept", {31'd0, ready_o}, 32'd1);
    tick();
    check("valid_after_1cyc", {31'd0, valid_o}, 32'd1);
    check("result", result_o, m[31:0]);
    check("zero", {31'd0, zero_o}, {31'd0, m[32]});
    check("branch", {31'd0, branch_o}, {31'd0, m[33]});
  endtask

  // Shift op: measure latency and ready_o-low cycles, scramble inputs meanwhile
  task automatic do_shift(input logic [3:0] op, input logic [31:0] a, input int s);
    logic [33:0] m;
    int lat;
    int low;
    int lat_exp;
    m         = model(op, a, 32'(s));
    lat_exp   = (s < 2) ? 1 : s;
    valid_i   = 1'b1;
    ready_i   = 1'b1;
    ALUCtrl_i = op;
    src1_i    = a;
    src2_i    = 32'(s);
    #1;
    check("shift_ready_before_accept", {31'd0, ready_o}, 32'd1);
    tick();
    valid_i   = 1'b0;
    src1_i    = $urandom;
    src2_i    = $urandom;
    ALUCtrl_i = 4'($urandom);
    lat = 1;
    low = 0;
    while (!valid_o && lat < 40) begin
      if (!ready_o) low++;
      tick();
      lat++;
    end
    check("shift_latency", 32'(lat), 32'(lat_exp));
    check("shift_ready_low_cycles", 32'(low), 32'(lat_exp - 1));
    check("shift_result", result_o, m[31:0]);
    check("shift_zero", {31'd0, zero_o}, {31'd0, m[32]});
    check("shift_branch", {31'd0, branch_o}, 32'd0);
    tick();
    check("shift_no_duplicate", {31'd0, valid_o}, 32'd0);
  endtask

  logic [3:0] ns_ops [9];
  logic [31:0] held;
  logic        seen;

  initial begin
    ns_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9, 4'd15, 4'd10};

    // Reset held two cycles with valid_i asserted
    rst_i     = 1'b1;
    valid_i   = 1'b1;
    ready_i   = 1'b1;
    ALUCtrl_i = 4'd2;
    src1_i    = 32'd7;
    src2_i    = 32'd9;
    tick();
    tick();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_zero", {31'd0, zero_o}, 32'd0);
    check("rst_branch", {31'd0, branch_o}, 32'd0);
    rst_i = 1'b0;

    // Back-to-back single-cycle ops, first accept right after release
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd3, 32'd5, 32'd7);
    issue(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(4'd1, 32'd1, 32'd2);
    issue(4'd0, 32'd6, 32'd3);
    check("and_literal", result_o, 32'd2);

    // Branches
    issue(4'd6, 32'h1234, 32'h1234);
    check("beq_taken", {31'd0, branch_o}, 32'd1);
    issue(4'd9, 32'h1234, 32'h1235);
    check("bne_result", result_o, 32'hFFFF_FFFF);
    issue(4'd9, 32'h55AA, 32'h55AA);
    check("bne_not_taken", {31'd0, branch_o}, 32'd0);

    // Undefined op code
    issue(4'd15, 32'hDEAD_BEEF, 32'h1234_5678);

    // Random single-cycle ops
    for (int i = 0; i < 20; i++) begin
      issue(ns_ops[$urandom_range(0, 8)], $urandom, $urandom);
    end

    // Shifts
    do_shift(4'd4, 32'h0000_0001, 31);
    do_shift(4'd5, 32'h8000_0000, 4);
    do_shift(4'd4, 32'hCAFE_0001, 0);
    do_shift(4'd5, 32'hCAFE_0001, 1);
    for (int i = 0; i < 5; i++) begin
      do_shift(($urandom_range(0, 1) == 0) ? 4'd4 : 4'd5, $urandom, $urandom_range(0, 31));
    end

    // Backpressure: result held, SRL waits for the slot
    valid_i   = 1'b1;
    ready_i   = 1'b0;
    ALUCtrl_i = 4'd2;
    src1_i    = 32'd10;
    src2_i    = 32'd20;
    tick();
    check("bp_first_valid", {31'd0, valid_o}, 32'd1);
    held      = result_o;
    check("bp_first_result", held, 32'd30);
    ALUCtrl_i = 4'd5;
    src1_i    = 32'hF000_0000;
    src2_i    = 32'd3;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready_low", {31'd0, ready_o}, 32'd0);
      tick();
      check("bp_result_stable", result_o, 32'd30);
      check("bp_valid_held", {31'd0, valid_o}, 32'd1);
    end
    ready_i = 1'b1;
    #1;
    check("bp_ready_release", {31'd0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    check("bp_consumed", {31'd0, valid_o}, 32'd0);
    tick();
    check("bp_shift_busy", {31'd0, valid_o}, 32'd0);
    tick();
    check("bp_shift_valid", {31'd0, valid_o}, 32'd1);
    check("bp_shift_result", result_o, 32'h1E00_0000);
    tick();
    check("bp_no_duplicate", {31'd0, valid_o}, 32'd0);

    // Reset in the middle of a long shift
    valid_i   = 1'b1;
    ALUCtrl_i = 4'd4;
    src1_i    = 32'd1;
    src2_i    = 32'd20;
    tick();
    valid_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    seen  = 1'b0;
    repeat (25) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    check("midshift_no_valid", {31'd0, seen}, 32'd0);
    check("midshift_idle_ready", {31'd0, ready_o}, 32'd1);
    check("midshift_result_cleared", result_o, 32'd0);

    // Unit is usable again after the abort
    issue(4'd3, 32'd100, 32'd1);
    valid_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
